// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the shared-ALU controller.
//   ALU_W / RES_W : operand and result widths
//   fn_e          : 2-bit ALU function codes
//   state_e       : controller FSM states
//   wrap_add      : modular index helper used by the round-robin scan
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int RES_W = 8;

  typedef enum logic [1:0] {
    FN_ADD = 2'b00,
    FN_OR  = 2'b01,
    FN_AND = 2'b10,
    FN_CAT = 2'b11
  } fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // (base + step) mod n, for walking requester indices with wrap-around.
  function automatic int wrap_add(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational 4-bit ALU.
// Ports:
//   a, b   : ALU_W-bit operands
//   fn     : function code (add / or-reduce / and-reduce / concatenate)
//   result : RES_W-bit result
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  fn_e              fn,
  output logic [RES_W-1:0] result
);

  // One extra bit keeps the carry of the unsigned add.
  logic [ALU_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    unique case (fn)
      FN_ADD: result = {{(RES_W-ALU_W-1){1'b0}}, sum};
      FN_OR:  result = {{(RES_W-1){1'b0}}, (|a) | (|b)};
      FN_AND: result = {{(RES_W-1){1'b0}}, (&a) & (&b)};
      FN_CAT: result = {a, b};
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl -- shares one ALU between NUM_REQ requesters.
// A round-robin arbiter picks a requester in IDLE and latches its operands,
// EXEC registers the ALU output, RESP pulses Ack to the owner for one cycle.
// Ports:
//   Clock, Reset_b : clock (rising edge), asynchronous active-low reset
//   Req            : per-requester level request
//   A_in, B_in     : packed 4-bit operands, requester i at [4i+3:4i]
//   Func_in        : packed 2-bit function codes, requester i at [2i+1:2i]
//   Ack            : one-hot, one-cycle completion pulse
//   Result         : result of the last completed operation
//   GrantId        : index of the current / last owner
//   Busy           : high while an operation is in EXEC or RESP
//   OpCount        : number of completed operations, wrapping
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int CNT_W   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     Clock,
  input  logic                     Reset_b,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [ALU_W*NUM_REQ-1:0] A_in,
  input  logic [ALU_W*NUM_REQ-1:0] B_in,
  input  logic [2*NUM_REQ-1:0]     Func_in,
  output logic [NUM_REQ-1:0]       Ack,
  output logic [RES_W-1:0]         Result,
  output logic [ID_W-1:0]          GrantId,
  output logic                     Busy,
  output logic [CNT_W-1:0]         OpCount
);

  state_e             state_reg;
  state_e             state_next;
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    grant_reg;
  logic [ALU_W-1:0]   a_reg;
  logic [ALU_W-1:0]   b_reg;
  fn_e                fn_reg;
  logic [RES_W-1:0]   result_reg;
  logic [CNT_W-1:0]   count_reg;

  logic [ALU_W-1:0]   a_arr  [NUM_REQ];
  logic [ALU_W-1:0]   b_arr  [NUM_REQ];
  fn_e                fn_arr [NUM_REQ];

  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    cand_idx;
  logic [RES_W-1:0]   alu_out;

  // Unpack the per-requester fields and decode the one-hot Ack.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]  = A_in[ALU_W*gi +: ALU_W];
      assign b_arr[gi]  = B_in[ALU_W*gi +: ALU_W];
      assign fn_arr[gi] = fn_e'(Func_in[2*gi +: 2]);
      assign Ack[gi]    = (state_reg == ST_RESP) && (grant_reg == ID_W'(gi));
    end
  endgenerate

  // Round-robin: scan from the requester after the last owner, with wrap,
  // and take the first one asserting Req.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = ID_W'(wrap_add(int'(ptr_reg), k, NUM_REQ));
      if (!win_valid && Req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  alu_core u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .fn     (fn_reg),
    .result (alu_out)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (win_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_reg  <= ST_IDLE;
      // Pointer starts at the last index so requester 0 is scanned first.
      ptr_reg    <= ID_W'(NUM_REQ - 1);
      grant_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      fn_reg     <= FN_ADD;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (win_valid) begin
            grant_reg <= win_idx;
            a_reg     <= a_arr[win_idx];
            b_reg     <= b_arr[win_idx];
            fn_reg    <= fn_arr[win_idx];
          end
        end
        ST_EXEC: result_reg <= alu_out;
        ST_RESP: begin
          ptr_reg   <= grant_reg;
          count_reg <= count_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign Result  = result_reg;
  assign GrantId = grant_reg;
  assign Busy    = (state_reg != ST_IDLE);
  assign OpCount = count_reg;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl -- self-checking bench for alu_share_ctrl.
// Directed vector table, a mid-operation asynchronous reset sequence,
// a counter-wrap sequence on a CNT_W=2 instance, and randomized traffic
// compared against a transaction-level reference model.
module tb_alu_share_ctrl;

  localparam int NR = 2;

  logic            Clock;
  logic            Reset_b;
  logic [NR-1:0]   Req;
  logic [4*NR-1:0] A_in;
  logic [4*NR-1:0] B_in;
  logic [2*NR-1:0] Func_in;

  logic [NR-1:0]   ack8, ack2;
  logic [7:0]      res8, res2;
  logic            gid8, gid2;
  logic            busy8, busy2;
  logic [7:0]      cnt8;
  logic [1:0]      cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_ctrl #(.NUM_REQ(NR), .CNT_W(8)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .Req(Req), .A_in(A_in), .B_in(B_in),
    .Func_in(Func_in), .Ack(ack8), .Result(res8), .GrantId(gid8),
    .Busy(busy8), .OpCount(cnt8)
  );

  alu_share_ctrl #(.NUM_REQ(NR), .CNT_W(2)) dut_w2 (
    .Clock(Clock), .Reset_b(Reset_b), .Req(Req), .A_in(A_in), .B_in(B_in),
    .Func_in(Func_in), .Ack(ack2), .Result(res2), .GrantId(gid2),
    .Busy(busy2), .OpCount(cnt2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_phase;   // cycles since grant: 0 waiting, 1 computing, 2 acknowledging
  int m_owner, m_ptr, m_ops, m_a, m_b, m_f, m_res;

  function automatic int alu_ref(input int a, input int b, input int f);
    case (f)
      0:       return a + b;
      1:       return (a != 0 || b != 0) ? 1 : 0;
      2:       return (a == 15 && b == 15) ? 1 : 0;
      default: return a * 16 + b;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = NR - 1; m_ops = 0; m_res = 0;
    m_a = 0; m_b = 0; m_f = 0;
  endtask

  task automatic model_step(input logic [NR-1:0] req, input logic [4*NR-1:0] a,
                            input logic [4*NR-1:0] b, input logic [2*NR-1:0] f);
    bit found;
    found = 0;
    if (m_phase == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (!found && req[i]) begin
          found = 1;
          m_owner = i;
          m_a = int'(a[4*i +: 4]);
          m_b = int'(b[4*i +: 4]);
          m_f = int'(f[2*i +: 2]);
        end
      end
      if (found) m_phase = 1;
    end else if (m_phase == 1) begin
      m_res = alu_ref(m_a, m_b, m_f);
      m_phase = 2;
    end else begin
      m_ptr = m_owner;
      m_ops++;
      m_phase = 0;
      $display("op %0d: owner=%0d a=%h b=%h f=%0d result=%h", m_ops, m_owner, m_a, m_b, m_f, m_res);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NR-1:0] e_ack;
    e_ack = (m_phase == 2) ? NR'(1 << m_owner) : '0;
    check({tag, " ack"},  32'(ack8),  32'(e_ack));
    check({tag, " res"},  32'(res8),  32'(m_res));
    check({tag, " gid"},  32'(gid8),  32'(m_owner));
    check({tag, " busy"}, 32'(busy8), 32'(m_phase != 0));
    check({tag, " cnt"},  32'(cnt8),  32'(m_ops % 256));
    check({tag, " cnt2"}, 32'(cnt2),  32'(m_ops % 4));
  endtask

  task automatic model_cycle(input string tag);
    model_step(Req, A_in, B_in, Func_in);
    @(posedge Clock); #1;
    check_model(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] f0, f1;
    logic [1:0] ack;
    logic [7:0] res;
    logic       gid;
    logic       busy;
    int         cnt;
  } vec_t;

  vec_t vecs [26];
  int   wrap_exp [5];

  initial begin
    // single op 9+8 on requester 0
    vecs[0]  = '{1'b1, 2'b01, 4'h9, 4'h8, 4'h0, 4'h0, 2'd0, 2'd0, 2'b00, 8'h00, 1'b0, 1'b1, 0};
    vecs[1]  = '{1'b0, 2'b01, 4'h9, 4'h8, 4'h0, 4'h0, 2'd0, 2'd0, 2'b01, 8'h11, 1'b0, 1'b1, 0};
    vecs[2]  = '{1'b0, 2'b00, 4'h9, 4'h8, 4'h0, 4'h0, 2'd0, 2'd0, 2'b00, 8'h11, 1'b0, 1'b0, 1};
    vecs[3]  = '{1'b0, 2'b00, 4'h9, 4'h8, 4'h0, 4'h0, 2'd0, 2'd0, 2'b00, 8'h11, 1'b0, 1'b0, 1};
    // both requesters held: grants alternate 0,1,0,1
    vecs[4]  = '{1'b1, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h00, 1'b0, 1'b1, 0};
    vecs[5]  = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b01, 8'h3C, 1'b0, 1'b1, 0};
    vecs[6]  = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h3C, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h3C, 1'b1, 1'b1, 1};
    vecs[8]  = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b10, 8'h01, 1'b1, 1'b1, 1};
    vecs[9]  = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h01, 1'b1, 1'b0, 2};
    vecs[10] = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h01, 1'b0, 1'b1, 2};
    vecs[11] = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b01, 8'h3C, 1'b0, 1'b1, 2};
    vecs[12] = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h3C, 1'b0, 1'b0, 3};
    vecs[13] = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h3C, 1'b1, 1'b1, 3};
    vecs[14] = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b10, 8'h01, 1'b1, 1'b1, 3};
    vecs[15] = '{1'b0, 2'b11, 4'h3, 4'hC, 4'hF, 4'hF, 2'd3, 2'd2, 2'b00, 8'h01, 1'b1, 1'b0, 4};
    // OR-reduce: 0|0 then 0|4
    vecs[16] = '{1'b0, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 2'd0, 2'b00, 8'h01, 1'b0, 1'b1, 4};
    vecs[17] = '{1'b0, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 2'd0, 2'b01, 8'h00, 1'b0, 1'b1, 4};
    vecs[18] = '{1'b0, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 2'd0, 2'b00, 8'h00, 1'b0, 1'b0, 5};
    vecs[19] = '{1'b0, 2'b01, 4'h0, 4'h4, 4'h0, 4'h0, 2'd1, 2'd0, 2'b00, 8'h00, 1'b0, 1'b1, 5};
    vecs[20] = '{1'b0, 2'b01, 4'h0, 4'h4, 4'h0, 4'h0, 2'd1, 2'd0, 2'b01, 8'h01, 1'b0, 1'b1, 5};
    vecs[21] = '{1'b0, 2'b00, 4'h0, 4'h4, 4'h0, 4'h0, 2'd1, 2'd0, 2'b00, 8'h01, 1'b0, 1'b0, 6};
    vecs[22] = '{1'b0, 2'b00, 4'h0, 4'h4, 4'h0, 4'h0, 2'd1, 2'd0, 2'b00, 8'h01, 1'b0, 1'b0, 6};
    // Req dropped and A changed after the latch edge: latched 2+3 completes
    vecs[23] = '{1'b0, 2'b01, 4'h2, 4'h3, 4'h0, 4'h0, 2'd0, 2'd0, 2'b00, 8'h01, 1'b0, 1'b1, 6};
    vecs[24] = '{1'b0, 2'b00, 4'hF, 4'h3, 4'h0, 4'h0, 2'd0, 2'd0, 2'b01, 8'h05, 1'b0, 1'b1, 6};
    vecs[25] = '{1'b0, 2'b00, 4'hF, 4'h3, 4'h0, 4'h0, 2'd0, 2'd0, 2'b00, 8'h05, 1'b0, 1'b0, 7};

    wrap_exp = '{1, 2, 3, 0, 1};

    Reset_b = 1'b0; Req = '0; A_in = '0; B_in = '0; Func_in = '0;
    #12;
    check("rst ack",  32'(ack8),  32'd0);
    check("rst res",  32'(res8),  32'd0);
    check("rst gid",  32'(gid8),  32'd0);
    check("rst busy", 32'(busy8), 32'd0);
    check("rst cnt",  32'(cnt8),  32'd0);
    @(posedge Clock); #1;

    for (int i = 0; i < 26; i++) begin
      if (vecs[i].rst) begin
        Reset_b = 1'b0; #2; Reset_b = 1'b1;
      end
      Req     = vecs[i].req;
      A_in    = {vecs[i].a1, vecs[i].a0};
      B_in    = {vecs[i].b1, vecs[i].b0};
      Func_in = {vecs[i].f1, vecs[i].f0};
      @(posedge Clock); #1;
      $display("vec %0d: req=%b ack=%b res=%h gid=%0d busy=%0d cnt=%0d",
               i, Req, ack8, res8, gid8, busy8, cnt8);
      check($sformatf("vec%0d ack", i),  32'(ack8),  32'(vecs[i].ack));
      check($sformatf("vec%0d res", i),  32'(res8),  32'(vecs[i].res));
      check($sformatf("vec%0d gid", i),  32'(gid8),  32'(vecs[i].gid));
      check($sformatf("vec%0d busy", i), 32'(busy8), 32'(vecs[i].busy));
      check($sformatf("vec%0d cnt", i),  32'(cnt8),  32'(vecs[i].cnt));
      check($sformatf("vec%0d cnt2", i), 32'(cnt2),  32'(vecs[i].cnt % 4));
    end

    // Asynchronous reset while in EXEC
    Req = 2'b01; A_in = 8'h11; B_in = 8'h11; Func_in = 4'h0;
    @(posedge Clock); #1;
    check("pre-abort busy", 32'(busy8), 32'd1);
    #1 Reset_b = 1'b0;
    #1;
    check("abort ack",  32'(ack8),  32'd0);
    check("abort res",  32'(res8),  32'd0);
    check("abort gid",  32'(gid8),  32'd0);
    check("abort busy", 32'(busy8), 32'd0);
    check("abort cnt",  32'(cnt8),  32'd0);
    #1 Reset_b = 1'b1;
    model_reset();
    Req = '0;
    model_cycle("post-abort idle0");
    model_cycle("post-abort idle1");

    // Five back-to-back ops; first one from requester 1 after the reset
    for (int op = 0; op < 5; op++) begin
      Req     = (op == 0) ? 2'b10 : 2'b01;
      A_in    = 8'($urandom);
      B_in    = 8'($urandom);
      Func_in = 4'($urandom);
      for (int c = 0; c < 3; c++) begin
        model_cycle($sformatf("wrap op%0d c%0d", op, c));
        if (op == 0 && c == 0) check("post-abort grant", 32'(gid8), 32'd1);
      end
      check($sformatf("wrap opcount op%0d", op), 32'(cnt2), 32'(wrap_exp[op]));
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      Req     = NR'($urandom);
      A_in    = 8'($urandom);
      B_in    = 8'($urandom);
      Func_in = 4'($urandom);
      model_cycle($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
